// File: rtl/mealy_1100_pkg.sv
// Shared types for the 1,1,0,0 serial pattern detector.
// The state encoding is fixed so that ps/ns can be read directly as 2-bit values.
package mealy_1100_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

endpackage

// File: rtl/mealy_1100_if.sv
// Detector signal bundle: the bench drives reset/in, the detector drives ns/ps/q.
// It is clocked by clk, which the bench-side modport carries for sampling.
interface mealy_1100_if
  import mealy_1100_pkg::*;
(
  input logic clk
);

  logic   reset;
  logic   in;
  state_t ns;
  state_t ps;
  logic   q;

  modport master (
    input  clk,
    input  ns,
    input  ps,
    input  q,
    output reset,
    output in
  );

  modport slave (
    input  in,
    output ns,
    output ps,
    output q
  );

endinterface

// File: rtl/mealy_1100.sv
// Mealy detector for the serial pattern 1,1,0,0 with overlap allowed.
// q is combinational from the present state and in, so it flags the final 0 before the edge.
module mealy_1100
  import mealy_1100_pkg::*;
(
  input logic         clk,
  input logic         reset,
  mealy_1100_if.slave bus
);

  state_t state_p0;
  state_t state_next;
  logic   detect;

  // Stage p0: present-state register; reset forces S0 without waiting for clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= S0;
    end else begin
      state_p0 <= state_next;
    end
  end

  always_comb begin
    state_next = S0;
    detect     = 1'b0;
    case (state_p0)
      S0: state_next = bus.in ? S1 : S0;
      S1: state_next = bus.in ? S2 : S0;
      // Extra 1s keep "11" as the longest matched prefix
      S2: state_next = bus.in ? S2 : S3;
      S3: begin
        // No suffix of 1100 is a prefix of the pattern, so a hit returns to S0
        state_next = bus.in ? S1 : S0;
        detect     = ~bus.in;
      end
      default: begin
        state_next = S0;
        detect     = 1'b0;
      end
    endcase
  end

  assign bus.ps = state_p0;
  assign bus.ns = state_next;
  assign bus.q  = detect;

endmodule

// File: tb/tb_mealy_1100.sv
// Directed bench for mealy_1100: hand-computed ps/ns/q for each bit presented on in.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_mealy_1100;
  import mealy_1100_pkg::*;

  logic clk;
  int   compared;
  int   mismatched;

  mealy_1100_if inter (.clk(clk));

  mealy_1100 dut (
    .clk   (clk),
    .reset (inter.reset),
    .bus   (inter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input state_t exp_ps, input state_t exp_ns,
                       input logic exp_q);
    compared++;
    assert (inter.ps === exp_ps)
    else begin
      mismatched++;
      $error("FAIL %s ps: observed %0d expected %0d", tag, inter.ps, exp_ps);
    end
    compared++;
    assert (inter.ns === exp_ns)
    else begin
      mismatched++;
      $error("FAIL %s ns: observed %0d expected %0d", tag, inter.ns, exp_ns);
    end
    compared++;
    assert (inter.q === exp_q)
    else begin
      mismatched++;
      $error("FAIL %s q: observed %0b expected %0b", tag, inter.q, exp_q);
    end
  endtask

  // Present one bit for one full cycle and check the combinational view of it
  task automatic step(input string tag, input logic bit_in, input state_t exp_ps,
                      input state_t exp_ns, input logic exp_q);
    @(negedge clk);
    inter.in = bit_in;
    #1;
    check(tag, exp_ps, exp_ns, exp_q);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    inter.reset = 1'b0;
    inter.in    = 1'b0;
    #3;
    check("rst_async", S0, S0, 1'b0);

    // Reset held for two cycles with in toggling
    step("rst_in1", 1'b1, S0, S1, 1'b0);
    step("rst_in0", 1'b0, S0, S0, 1'b0);
    step("rst_in1b", 1'b1, S0, S1, 1'b0);

    @(negedge clk);
    inter.reset = 1'b1;
    inter.in    = 1'b0;
    #1;
    check("rel_0a", S0, S0, 1'b0);
    step("rel_0b", 1'b0, S0, S0, 1'b0);
    step("rel_0c", 1'b0, S0, S0, 1'b0);

    // Basic 1,1,0,0
    step("b_1", 1'b1, S0, S1, 1'b0);
    step("b_2", 1'b1, S1, S2, 1'b0);
    step("b_3", 1'b0, S2, S3, 1'b0);
    step("b_4", 1'b0, S3, S0, 1'b1);

    // Extra ones: 1,1,1,1,0,0
    step("x_1", 1'b1, S0, S1, 1'b0);
    step("x_2", 1'b1, S1, S2, 1'b0);
    step("x_3", 1'b1, S2, S2, 1'b0);
    step("x_4", 1'b1, S2, S2, 1'b0);
    step("x_5", 1'b0, S2, S3, 1'b0);
    step("x_6", 1'b0, S3, S0, 1'b1);

    // Back-to-back: 1,1,0,0,1,1,0,0
    step("bb_1", 1'b1, S0, S1, 1'b0);
    step("bb_2", 1'b1, S1, S2, 1'b0);
    step("bb_3", 1'b0, S2, S3, 1'b0);
    step("bb_4", 1'b0, S3, S0, 1'b1);
    step("bb_5", 1'b1, S0, S1, 1'b0);
    step("bb_6", 1'b1, S1, S2, 1'b0);
    step("bb_7", 1'b0, S2, S3, 1'b0);
    step("bb_8", 1'b0, S3, S0, 1'b1);

    // Broken pattern: 1,1,0,1,1,0,0 (S3 with in=1 goes to S1)
    step("br_1", 1'b1, S0, S1, 1'b0);
    step("br_2", 1'b1, S1, S2, 1'b0);
    step("br_3", 1'b0, S2, S3, 1'b0);
    step("br_4", 1'b1, S3, S1, 1'b0);
    step("br_5", 1'b1, S1, S2, 1'b0);
    step("br_6", 1'b0, S2, S3, 1'b0);
    step("br_7", 1'b0, S3, S0, 1'b1);

    // 1,1,0 then an asynchronous reset pulse mid-cycle, then 0
    step("ar_1", 1'b1, S0, S1, 1'b0);
    step("ar_2", 1'b1, S1, S2, 1'b0);
    step("ar_3", 1'b0, S2, S3, 1'b0);
    @(posedge clk);
    #1;
    compared++;
    assert (inter.ps === S3)
    else begin
      mismatched++;
      $error("FAIL ar_pre ps: observed %0d expected %0d", inter.ps, S3);
    end
    #1;
    inter.reset = 1'b0;
    #1;
    check("ar_pulse", S0, S0, 1'b0);
    #1;
    inter.reset = 1'b1;
    step("ar_4", 1'b0, S0, S0, 1'b0);
    step("ar_5", 1'b0, S0, S0, 1'b0);

    // A full pattern is needed again after the reset
    step("rc_1", 1'b1, S0, S1, 1'b0);
    step("rc_2", 1'b1, S1, S2, 1'b0);
    step("rc_3", 1'b0, S2, S3, 1'b0);
    step("rc_4", 1'b0, S3, S0, 1'b1);
    step("rc_5", 1'b0, S0, S0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mealy_1100.md
MEALY_1100 -- requirements
Module: mealy_1100

Interface
REQ-001 Parameters: none; state encoding is fixed (see REQ-009).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets; reset=1 runs).
REQ-004 in  input  1  serial data bit, one bit sampled per rising clk edge.
REQ-005 ns  output  2  next-state value, combinational from ps and in.
REQ-006 ps  output  2  present-state value, registered.
REQ-007 q  output  1  detection flag, Mealy (combinational from ps and in).

Function
REQ-008 The block SHALL detect the serial pattern 1,1,0,0 (oldest bit first) on in, with overlapping detection allowed.
REQ-009 States SHALL be encoded as follows:
- S0=2'b00: no prefix matched.
- S1=2'b01: "1" matched.
- S2=2'b10: "11" matched.
- S3=2'b11: "110" matched.
REQ-010 Transitions (ps,in -> ns) SHALL be:
- S0: in=0 -> S0; in=1 -> S1.
- S1: in=0 -> S0; in=1 -> S2.
- S2: in=0 -> S3; in=1 -> S2.
- S3: in=0 -> S0; in=1 -> S1.
REQ-011 In S2 with in=1, the state SHALL remain S2, since the longest matched prefix is still "11".
REQ-012 After a detection (S3 with in=0), ns SHALL be S0, because no suffix of "1100" is a pattern prefix.
REQ-013 q SHALL be 1 exactly when ps==S3 and in==0, and 0 otherwise.
- Zero latency: q asserts in the same cycle the final 0 is presented, before the clock edge.
REQ-014 ns SHALL follow REQ-010 combinationally for every ps/in combination, including while reset is asserted.
REQ-015 ps SHALL load ns on each rising clk edge while reset==1.
REQ-016 An unknown or illegal ps value SHALL give ns=S0 and q=0 (default branch).
REQ-017 ns and q SHALL be fully assigned in all branches, so that no latches are inferred.

Reset
REQ-018 reset==0 SHALL force ps=S0 immediately, independent of clk.
REQ-019 While reset==0, ps SHALL hold S0, and ns/q SHALL reflect S0 with the current in (q=0).
REQ-020 Reset asserted mid-pattern SHALL discard all partial match history.
- After release, a full 1,1,0,0 is required before q asserts.
REQ-021 Release of reset SHALL take effect at the next rising clk edge; no synchronizer is required inside the block.

Structure
REQ-022 The state type (2-bit enum S0..S3) SHALL live in a shared package, mealy_1100_pkg, used by the RTL and the verification interface.
REQ-023 The RTL SHALL consist of one sequential process for ps and one combinational process for ns and q.
- No sub-module is needed.
REQ-024 The bench SHALL connect through an interface, inter, carrying reset, in, ns, ps and q and clocked by clk.
- Stimulus SHALL be driven by a program/module, test, and the 10-time-unit clock generated in the top level.

Verification
REQ-025 Hold reset=0 for 2 cycles, with in toggling:
- Required: ps=S0 throughout, q=0.
- Then release reset=1 and drive in=0 for 3 cycles: ps stays S0.
REQ-026 Drive in=1,1,0,0 after reset:
- Required ps sequence: S0->S1->S2->S3.
- q=1 only during the 4th bit (in=0, ps=S3); ps=S0 after that edge.
REQ-027 Drive in=1,1,1,1,0,0:
- Required: ps stays S2 through the extra 1s.
- q pulses once, on the final 0.
REQ-028 Drive in=1,1,0,0,1,1,0,0 (overlap/back-to-back):
- Required: q pulses on bit 4 and bit 8, and nowhere else.
REQ-029 Drive in=1,1,0,1,1,0,0:
- Required: S3 with in=1 moves to S1 and no detect occurs on bit 3.
- q pulses only on bit 7.
REQ-030 Drive in=1,1,0, then pulse reset=0 mid-cycle (asynchronous), then drive in=0:
- Required: ps=S0 immediately on the reset pulse and q=0.
- No detection follows.
